// File: rtl/tdm_demux_rx.sv
// ---------------------------------------------------------------------------
// tdm_demux_rx
//
// Receive end of a keyed TDM serial link. The transmitter XORs each serial
// bit with a key bit; this block registers the line, XORs again with the
// same key bit to recover the data, aligns to frames using fsync and
// demultiplexes N_SLOTS slots into a parallel channel word.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active high
//   din         scrambled serial data bit
//   f           key bit, cycle-aligned with din
//   fsync       high with the slot-0 bit of each frame
//   in_valid    din/f/fsync valid this cycle
//   ch_out      descrambled frame, bit i = slot i
//   frame_valid one-cycle pulse when ch_out is updated
//   locked      frame alignment acquired
//   slot        slot index of the sample held in the input stage
//   sync_err    one-cycle pulse on misplaced or missing fsync
// ---------------------------------------------------------------------------
module tdm_demux_rx #(
    parameter int N_SLOTS  = 4,
    parameter int SLOT_W   = 2,
    parameter int MISS_MAX = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               f,
    input  logic               fsync,
    input  logic               in_valid,
    output logic [N_SLOTS-1:0] ch_out,
    output logic               frame_valid,
    output logic               locked,
    output logic [SLOT_W-1:0]  slot,
    output logic               sync_err
);

    localparam int MW = $clog2(MISS_MAX + 1);

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOTS - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
    localparam logic [MW-1:0]     MISS_LIM  = MW'(MISS_MAX);

    logic               din_r;
    logic               f_r;
    logic               fs_r;
    logic               v_r;
    logic [0:0]         state;
    logic [N_SLOTS-1:0] shadow;
    logic [MW-1:0]      miss_cnt;
    logic [MW-1:0]      miss_next;
    logic               b;

    // The key is applied bit by bit with no stored key state, so a wrong key
    // only garbles data and never disturbs the alignment logic.
    assign b         = din_r ^ f_r;
    assign miss_next = miss_cnt + 1'b1;

    // Input stage: the raw line is registered every cycle so that the
    // scrambled bit is the only thing visible on the wire side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_r <= 1'b0;
            f_r   <= 1'b0;
            fs_r  <= 1'b0;
            v_r   <= 1'b0;
        end else begin
            din_r <= din;
            f_r   <= f;
            fs_r  <= fsync;
            v_r   <= in_valid;
        end
    end

    // Framing stage. HUNT waits for an fsync to start a frame; LOCK walks the
    // slots, checks that fsync lines up with slot 0, flywheels over a few
    // missing syncs and realigns immediately on a misplaced one. Pulses are
    // cleared every cycle so they can never stretch; invalid samples leave
    // all state untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            shadow      <= '0;
            miss_cnt    <= '0;
            slot        <= '0;
            locked      <= 1'b0;
            ch_out      <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (v_r) begin
                if (state == HUNT) begin
                    if (fs_r) begin
                        shadow[0] <= b;
                        slot      <= SLOT_ONE;
                        locked    <= 1'b1;
                        miss_cnt  <= '0;
                        state     <= LOCK;
                    end
                end else if (slot == '0) begin
                    if (fs_r) begin
                        shadow[0] <= b;
                        miss_cnt  <= '0;
                        slot      <= SLOT_ONE;
                    end else begin
                        sync_err <= 1'b1;
                        if (miss_next == MISS_LIM) begin
                            // Too many missing syncs: give up and drop this bit.
                            locked   <= 1'b0;
                            state    <= HUNT;
                            slot     <= '0;
                            miss_cnt <= '0;
                        end else begin
                            miss_cnt  <= miss_next;
                            shadow[0] <= b;
                            slot      <= SLOT_ONE;
                        end
                    end
                end else if (fs_r) begin
                    // Sync in the wrong place: abandon the partial frame and
                    // treat this bit as the start of a new one.
                    sync_err  <= 1'b1;
                    shadow[0] <= b;
                    slot      <= SLOT_ONE;
                    miss_cnt  <= '0;
                end else begin
                    shadow[slot] <= b;
                    if (slot == LAST_SLOT) begin
                        ch_out      <= {b, shadow[N_SLOTS-2:0]};
                        frame_valid <= 1'b1;
                        slot        <= '0;
                    end else begin
                        slot <= slot + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_rx.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_rx
//
// Self-checking bench for tdm_demux_rx. Expected frames are pushed into a
// queue when stimulus is issued; a monitor pops and compares them whenever
// frame_valid is seen. Direct checks cover reset, lock, slot and sync_err.
// ---------------------------------------------------------------------------
module tb_tdm_demux_rx;

    logic       clk;
    logic       rst;
    logic       din;
    logic       f;
    logic       fsync;
    logic       in_valid;
    logic [3:0] ch_out;
    logic       frame_valid;
    logic       locked;
    logic [1:0] slot;
    logic       sync_err;

    int tests_run  = 0;
    int fail_count = 0;
    int fv_count   = 0;
    int se_count   = 0;

    logic [3:0] exp_q[$];

    tdm_demux_rx #(
        .N_SLOTS (4),
        .SLOT_W  (2),
        .MISS_MAX(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .f          (f),
        .fsync      (fsync),
        .in_valid   (in_valid),
        .ch_out     (ch_out),
        .frame_valid(frame_valid),
        .locked     (locked),
        .slot       (slot),
        .sync_err   (sync_err)
    );

    // Free-running clock, active edge is posedge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Monitor: on every negedge, compare a presented frame with the oldest
    // expected one and count sync_err pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid) begin
                fv_count++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    fail_count++;
                    $display("[TB] FAIL frame: unexpected frame_valid, ch_out=%b", ch_out);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    if (ch_out !== e) begin
                        fail_count++;
                        $display("[TB] FAIL frame: ch_out=%b expected %b", ch_out, e);
                    end
                end
            end
            if (sync_err) se_count++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Present one input sample at a negedge, return at the next negedge
    // (after the DUT has captured it).
    task automatic applyStimulus(input logic d, input logic k, input logic fs, input logic v);
        din      = d;
        f        = k;
        fsync    = fs;
        in_valid = v;
        @(negedge clk);
    endtask

    task automatic sendIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Send four bits, slot 0 first, with fsync optionally on the first bit.
    task automatic sendFrame(input logic [3:0] d, input logic [3:0] k, input logic fs_first);
        for (int i = 0; i < 4; i++) applyStimulus(d[i], k[i], (i == 0) ? fs_first : 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; din = 1'b0; f = 1'b0; fsync = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset ch_out", 32'(ch_out), 32'h0);
        checkOutput("reset frame_valid", 32'(frame_valid), 32'h0);
        checkOutput("reset locked", 32'(locked), 32'h0);
        checkOutput("reset slot", 32'(slot), 32'h0);
        checkOutput("reset sync_err", 32'(sync_err), 32'h0);
        rst = 1'b0;

        // No fsync: nothing should lock or be emitted.
        for (int i = 0; i < 10; i++) applyStimulus(i[0], 1'b0, 1'b0, 1'b1);
        sendIdle(2);
        checkOutput("hunt locked", 32'(locked), 32'h0);
        checkOutput("hunt frames", 32'(fv_count), 32'd0);

        // Plain frame, key 0: bits 1,0,1,1 -> 1101, with latency check.
        exp_q.push_back(4'b1101);
        sendFrame(4'b1101, 4'b0000, 1'b1);
        checkOutput("latency fv early", 32'(frame_valid), 32'h0);
        sendIdle(1);
        checkOutput("latency fv", 32'(frame_valid), 32'h1);
        checkOutput("locked after frame", 32'(locked), 32'h1);
        sendIdle(1);
        checkOutput("fv single cycle", 32'(frame_valid), 32'h0);

        // Constant key 1: din 0,1,0,0 -> 1101.
        exp_q.push_back(4'b1101);
        sendFrame(4'b0010, 4'b1111, 1'b1);
        // Key 1,0,1,0 with din 0,0,0,1 -> 1101.
        exp_q.push_back(4'b1101);
        sendFrame(4'b1000, 4'b0101, 1'b1);
        sendIdle(2);

        // Gap of 3 invalid cycles between slots 1 and 2: 1,1,0,0 -> 0011.
        exp_q.push_back(4'b0011);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        sendIdle(3);
        checkOutput("gap slot hold", 32'(slot), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        sendIdle(2);
        #1;
        checkOutput("no sync_err so far", 32'(se_count), 32'd0);

        // Misplaced fsync on slot 2 realigns; 0,1,1,0 -> 0110.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(4'b0110);
        sendFrame(4'b0110, 4'b0000, 1'b1);
        sendIdle(2);
        #1;
        checkOutput("misplaced sync_err", 32'(se_count), 32'd1);
        checkOutput("misplaced locked", 32'(locked), 32'h1);

        // First missing sync flywheels: 1,0,0,0 -> 0001 still emitted.
        exp_q.push_back(4'b0001);
        sendFrame(4'b0001, 4'b0000, 1'b0);
        sendIdle(1);
        checkOutput("flywheel locked", 32'(locked), 32'h1);
        // Second missing sync drops lock; rest discarded.
        sendFrame(4'b1111, 4'b0000, 1'b0);
        sendFrame(4'b1111, 4'b0000, 1'b0);
        sendIdle(2);
        #1;
        checkOutput("miss sync_err", 32'(se_count), 32'd3);
        checkOutput("miss locked", 32'(locked), 32'h0);
        checkOutput("miss slot", 32'(slot), 32'd0);
        // Sync returns: 0,1,0,1 -> 1010.
        exp_q.push_back(4'b1010);
        sendFrame(4'b1010, 4'b0000, 1'b1);
        sendIdle(2);
        checkOutput("relock", 32'(locked), 32'h1);

        // Reset in the middle of a frame clears outputs at once.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst ch_out", 32'(ch_out), 32'h0);
        checkOutput("async rst locked", 32'(locked), 32'h0);
        checkOutput("async rst slot", 32'(slot), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sendFrame(4'b1111, 4'b0000, 1'b0);
        sendIdle(2);
        checkOutput("post rst no lock", 32'(locked), 32'h0);
        exp_q.push_back(4'b0111);
        sendFrame(4'b0111, 4'b0000, 1'b1);
        sendIdle(3);
        #1;

        checkOutput("total frames", 32'(fv_count), 32'd8);
        checkOutput("total sync_err", 32'(se_count), 32'd3);
        checkOutput("queue empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule

// File: doc/tdm_demux_rx.md
Name: tdm_demux_rx

Overview:
- Receive end of the keyed TDM serial link; the transmit side scrambles one serial bit per cycle with a key bit (XOR).
- Registers the serial stream, XORs it again with the same key to descramble, and aligns to frames with a frame-sync marker.
- Demultiplexes N_SLOTS time slots into a parallel channel word.
- Tracks lock and flags sync loss, so a Trojan tap on the line sees only scrambled data.

Parameters:
N_SLOTS, 4, time slots per frame (>=2)
SLOT_W, 2, slot counter width, clog2(N_SLOTS)
MISS_MAX, 2, consecutive frames with missing sync before lock is dropped (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active high
din  input  1  scrambled serial data bit
f  input  1  key bit, cycle-aligned with din
fsync  input  1  high with the slot-0 bit of each frame
in_valid  input  1  din/f/fsync valid this cycle
ch_out  output  N_SLOTS  descrambled frame; bit i = slot i
frame_valid  output  1  one-cycle pulse when ch_out is updated
locked  output  1  frame alignment acquired
slot  output  SLOT_W  slot index of the sample in the input stage
sync_err  output  1  one-cycle pulse on misplaced or missing fsync

Behaviour:
- Reset (async, rst=1):
  - ch_out=0, frame_valid=0, locked=0, slot=0, sync_err=0.
  - Input stage, shadow register and miss counter are cleared; FSM goes to HUNT.
- Stage 1, edge E: din, f, fsync and in_valid are captured into din_r, f_r, fs_r and v_r.
- Stage 2, edge E+1: if v_r=1, the sample is processed with b = din_r ^ f_r.
- If v_r=0: no state change and no pulses; slot holds.
- FSM state HUNT:
  - A sample with fs_r=0 is discarded.
  - A sample with fs_r=1 writes b to shadow[0], sets slot=1, sets locked=1 and moves to LOCK.
- FSM state LOCK, sample at slot k:
  - k!=0 and fs_r=0: shadow[k]=b; slot=k+1, wrapping N_SLOTS-1 -> 0.
  - k=N_SLOTS-1: at the same edge, ch_out={b, shadow[N_SLOTS-2:0]}, frame_valid=1, slot=0.
  - k=0 and fs_r=1: shadow[0]=b, miss counter cleared.
  - k=0 and fs_r=0: sync_err=1 and the miss counter increments. The bit is still stored as slot 0 (flywheel).
    - If the count reaches MISS_MAX: locked=0, go to HUNT, slot=0, and the sample is discarded.
  - k!=0 and fs_r=1 (misplaced sync): sync_err=1, partial frame abandoned with no frame_valid. Realign: shadow[0]=b, slot=1, miss counter cleared, stay in LOCK.
- Latency: the last slot bit of a frame is captured at edge E; ch_out and frame_valid are updated at edge E+1 when in_valid is continuous.
- in_valid gaps inside a frame are tolerated; slots are counted on valid samples only.
- frame_valid and sync_err are single-cycle and never stretched.
- ch_out holds its value between frames.
- Reset mid-frame discards the partial frame. The first frame_valid after reset needs a fresh fsync.
- Key handling: f is applied per bit with no internal key state. A key mismatch corrupts only data bits, never alignment.

Test Plan:
- Reset, all inputs 0 -> all outputs 0, locked=0; 10 cycles with fsync=0 -> no frame_valid.
- f=0; fsync on the first bit; din=1,0,1,1 -> frame_valid pulse 2 cycles after the 4th bit is driven, ch_out=4'b1101, locked=1.
- f=1 constant; din=0,1,0,0 with fsync on the first bit -> ch_out=4'b1101. Repeat with f=1,0,1,0 and din=0,0,0,1 -> ch_out=4'b1101.
- Frame 1,1,0,0 with in_valid=0 for 3 cycles between slots 1 and 2 -> ch_out=4'b0011, one frame_valid, slot holds at 2 during the gap.
- After lock, fsync asserted on slot 2 -> sync_err pulse, no frame_valid for that frame. The next 4 valid bits 0,1,1,0 (starting with that fsync bit) -> ch_out=4'b0110.
- After lock, fsync withheld for 2 frames (MISS_MAX=2) -> sync_err at each slot 0, locked=0 after the second miss, no further frame_valid until fsync returns. Also: rst pulsed mid-frame -> outputs cleared immediately.
